// File: rtl/ram_arbiter_if.sv
// Bus bundle between the RAM arbiter and its requesters and RAM.
// ARB_VIDEO_PORT_EN adds the video fetch signals.
interface ram_arbiter_if #(
  parameter int ADDR_W = 25
);
  logic              dl_active;
  logic              dl_wr;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic              dl_overrun;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;
  logic              cpu_wait;
  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
`ifdef ARB_VIDEO_PORT_EN
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [7:0]        vid_data;
  logic              vid_ack;

  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_dout, vid_req, vid_addr,
    output dl_overrun, cpu_rdata, cpu_ack, cpu_wait,
    output mem_ce, mem_we, mem_addr, mem_din,
    output vid_data, vid_ack
  );
  modport master (
    output dl_active, dl_wr, dl_addr, dl_data,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_dout, vid_req, vid_addr,
    input  dl_overrun, cpu_rdata, cpu_ack, cpu_wait,
    input  mem_ce, mem_we, mem_addr, mem_din,
    input  vid_data, vid_ack
  );
`else
  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_dout,
    output dl_overrun, cpu_rdata, cpu_ack, cpu_wait,
    output mem_ce, mem_we, mem_addr, mem_din
  );
  modport master (
    output dl_active, dl_wr, dl_addr, dl_data,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_dout,
    input  dl_overrun, cpu_rdata, cpu_ack, cpu_wait,
    input  mem_ce, mem_we, mem_addr, mem_din
  );
`endif
endinterface

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: video (ARB_VIDEO_PORT_EN) > download > CPU,
// one access at a time with a fixed MEM_LAT latency.
module ram_arbiter #(
  parameter int ADDR_W  = 25,
  parameter int MEM_LAT = 2
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [1:0] {G_DL, G_CPU, G_VID} gnt_e;

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  logic [2:0]        lat_q, lat_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              dlv_q, dlv_d;
  logic [ADDR_W-1:0] dlb_addr_q, dlb_addr_d;
  logic [7:0]        dlb_data_q, dlb_data_d;
  logic              ovr_q, ovr_d;
  logic              dl_drain, dl_take, dl_pend;
  logic              cpu_pend, vid_pend;
  logic [ADDR_W-1:0] vid_addr_w;

`ifdef ARB_VIDEO_PORT_EN
  logic              vid_ack_q, vid_ack_d;
  logic [7:0]        vid_data_q, vid_data_d;
  assign vid_pend   = bus.vid_req & ~vid_ack_q;
  assign vid_addr_w = bus.vid_addr;
`else
  assign vid_pend   = 1'b0;
  assign vid_addr_w = '0;
`endif

  assign dl_drain = (state_q == DONE) && (gnt_q == G_DL);
  assign dl_take  = bus.dl_wr & (~dlv_q | dl_drain);
  // A beat arriving in IDLE is granted straight from the inputs
  assign dl_pend  = dlv_q | bus.dl_wr;
  assign cpu_pend = bus.cpu_req & ~cpu_ack_q & ~bus.dl_active;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    lat_d       = lat_q;
    mem_ce_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dlv_d       = dlv_q;
    dlb_addr_d  = dlb_addr_q;
    dlb_data_d  = dlb_data_q;
    ovr_d       = ovr_q;
`ifdef ARB_VIDEO_PORT_EN
    vid_ack_d   = 1'b0;
    vid_data_d  = vid_data_q;
`endif
    if (dl_drain) dlv_d = 1'b0;
    if (dl_take) begin
      dlv_d      = 1'b1;
      dlb_addr_d = bus.dl_addr;
      dlb_data_d = bus.dl_data;
    end else if (bus.dl_wr) begin
      ovr_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        priority case (1'b1)
          vid_pend: begin
            gnt_d      = G_VID;
            mem_we_d   = 1'b0;
            mem_addr_d = vid_addr_w;
          end
          dl_pend: begin
            gnt_d      = G_DL;
            mem_we_d   = 1'b1;
            mem_addr_d = dlv_q ? dlb_addr_q : bus.dl_addr;
            mem_din_d  = dlv_q ? dlb_data_q : bus.dl_data;
          end
          cpu_pend: begin
            gnt_d      = G_CPU;
            mem_we_d   = bus.cpu_we;
            mem_addr_d = bus.cpu_addr;
            if (bus.cpu_we) mem_din_d = bus.cpu_wdata;
          end
          default: ;
        endcase
        if (vid_pend | dl_pend | cpu_pend) begin
          state_d  = BUSY;
          mem_ce_d = 1'b1;
          lat_d    = 3'(MEM_LAT - 1);
        end
      end
      BUSY: begin
        if (lat_q == 3'd0) state_d = DONE;
        else lat_d = lat_q - 3'd1;
      end
      DONE: begin
        state_d = IDLE;
        // An abandoned request still completes, just without the ack
        if (gnt_q == G_CPU) begin
          cpu_ack_d = bus.cpu_req;
          if (!mem_we_q) cpu_rdata_d = bus.mem_dout;
        end
`ifdef ARB_VIDEO_PORT_EN
        if (gnt_q == G_VID) begin
          vid_ack_d  = bus.vid_req;
          vid_data_d = bus.mem_dout;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= G_DL;
      lat_q       <= '0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dlv_q       <= 1'b0;
      dlb_addr_q  <= '0;
      dlb_data_q  <= '0;
      ovr_q       <= 1'b0;
`ifdef ARB_VIDEO_PORT_EN
      vid_ack_q   <= 1'b0;
      vid_data_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      lat_q       <= lat_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dlv_q       <= dlv_d;
      dlb_addr_q  <= dlb_addr_d;
      dlb_data_q  <= dlb_data_d;
      ovr_q       <= ovr_d;
`ifdef ARB_VIDEO_PORT_EN
      vid_ack_q   <= vid_ack_d;
      vid_data_q  <= vid_data_d;
`endif
    end
  end

  assign bus.mem_ce     = mem_ce_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_wait   = (bus.cpu_req & ~cpu_ack_q) | bus.dl_active;
  assign bus.dl_overrun = ovr_q;
`ifdef ARB_VIDEO_PORT_EN
  assign bus.vid_ack    = vid_ack_q;
  assign bus.vid_data   = vid_data_q;
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: expected RAM accesses and acks
// are queued at stimulus time and checked as the DUT produces them.
module tb_ram_arbiter;
  localparam int AW  = 25;
  localparam int LAT = 2;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } acc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  acc_t exp_q[$];
  acc_t ack_q[$];
  acc_t mon_e, ack_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   cpu_acks = 0;
  int   vid_acks = 0;
  int   wait_low, a0;
  logic [7:0] ram [0:65535];

  ram_arbiter_if #(.ADDR_W(AW)) bus();

  ram_arbiter #(.ADDR_W(AW), .MEM_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cpu_ack(input int lim);
    int k = 0;
    while (!bus.cpu_ack && k < lim) begin
      tick();
      k++;
    end
    if (!bus.cpu_ack) check("cpu_ack_timeout", 0, 1);
    bus.cpu_req = 1'b0;
  endtask

  // RAM model and scoreboard monitor
  always @(negedge clk) begin
    if (!reset && bus.mem_ce) begin
      if (exp_q.size() == 0) begin
        check("mem_unexpected", {7'd0, bus.mem_addr}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("mem_we", {31'd0, bus.mem_we}, {31'd0, mon_e.we});
        check("mem_addr", {7'd0, bus.mem_addr}, {7'd0, mon_e.addr});
        if (mon_e.we) check("mem_din", {24'd0, bus.mem_din}, {24'd0, mon_e.data});
      end
      if (bus.mem_we) ram[bus.mem_addr[15:0]] = bus.mem_din;
    end
    bus.mem_dout = ram[bus.mem_addr[15:0]];
    if (!reset && bus.cpu_ack) begin
      cpu_acks++;
      if (ack_q.size() == 0) begin
        check("ack_unexpected", 1, 0);
      end else begin
        ack_e = ack_q.pop_front();
        if (!ack_e.we) check("cpu_rdata", {24'd0, bus.cpu_rdata}, {24'd0, ack_e.data});
      end
    end
`ifdef ARB_VIDEO_PORT_EN
    if (!reset && bus.vid_ack) begin
      vid_acks++;
      check("vid_data", {24'd0, bus.vid_data}, 32'hA5);
    end
`endif
  end

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'hA5;
    bus.dl_active = 0; bus.dl_wr = 0; bus.dl_addr = '0; bus.dl_data = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.mem_dout = '0;
`ifdef ARB_VIDEO_PORT_EN
    bus.vid_req = 0; bus.vid_addr = '0;
`endif

    // Reset with a pending CPU read, then its latency
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 25'h0100;
    exp_q.push_back('{1'b0, 25'h0100, 8'h00});
    ack_q.push_back('{1'b0, 25'h0100, 8'hA5});
    tick(3);
    check("rst_mem_ce", {31'd0, bus.mem_ce}, 0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 0);
    check("rst_mem_addr", {7'd0, bus.mem_addr}, 0);
    check("rst_mem_din", {24'd0, bus.mem_din}, 0);
    check("rst_cpu_ack", {31'd0, bus.cpu_ack}, 0);
    check("rst_cpu_rdata", {24'd0, bus.cpu_rdata}, 0);
    check("rst_overrun", {31'd0, bus.dl_overrun}, 0);
    check("rst_cpu_wait", {31'd0, bus.cpu_wait}, 1);
    reset = 0;
    #1 check("ce_at_release", {31'd0, bus.mem_ce}, 0);
    tick();
    check("ce_at_T", {31'd0, bus.mem_ce}, 1);
    tick();
    check("ack_T1", {31'd0, bus.cpu_ack}, 0);
    tick();
    check("ack_T2", {31'd0, bus.cpu_ack}, 0);
    tick();
    check("ack_T3", {31'd0, bus.cpu_ack}, 1);
    check("rdata_T3", {24'd0, bus.cpu_rdata}, 32'hA5);
    bus.cpu_req = 0;
    #1 check("wait_idle", {31'd0, bus.cpu_wait}, 0);
    tick();

    // Download stream every 4 cycles with a CPU write held off
    bus.dl_active = 1;
    #1 check("wait_dl_rise", {31'd0, bus.cpu_wait}, 1);
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 25'h4000; bus.cpu_wdata = 8'h77;
    wait_low = 0;
    for (int i = 0; i < 256; i++) begin
      bus.dl_wr = 1; bus.dl_addr = AW'(i); bus.dl_data = 8'(i) ^ 8'h3C;
      exp_q.push_back('{1'b1, AW'(i), 8'(i) ^ 8'h3C});
      tick();
      bus.dl_wr = 0;
      for (int c = 0; c < 4; c++) begin
        if (!bus.cpu_wait) wait_low++;
        if (c < 3) tick();
      end
    end
    tick(4);
    check("wait_dl", wait_low, 0);
    check("dl_no_overrun", {31'd0, bus.dl_overrun}, 0);
    check("dl_drained", exp_q.size(), 0);
    exp_q.push_back('{1'b1, 25'h4000, 8'h77});
    ack_q.push_back('{1'b1, 25'h4000, 8'h77});
    bus.dl_active = 0;
    wait_cpu_ack(20);

    // Download every 2 cycles: every other beat is dropped
    bus.dl_active = 1;
    for (int i = 0; i < 8; i++) begin
      bus.dl_wr = 1; bus.dl_addr = AW'(32'h2000 + i); bus.dl_data = 8'(8'hE0 + i);
      if (i % 2 == 0) exp_q.push_back('{1'b1, AW'(32'h2000 + i), 8'(8'hE0 + i)});
      tick();
      bus.dl_wr = 0;
      tick();
    end
    bus.dl_active = 0;
    tick(6);
    check("overrun_set", {31'd0, bus.dl_overrun}, 1);
    check("overrun_drained", exp_q.size(), 0);
    reset = 1;
    tick();
    reset = 0;
    check("overrun_cleared", {31'd0, bus.dl_overrun}, 0);

    // Download beat and CPU write in the same idle cycle
    bus.dl_wr = 1; bus.dl_addr = 25'h1234; bus.dl_data = 8'hC3;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 25'h8000; bus.cpu_wdata = 8'h5A;
    exp_q.push_back('{1'b1, 25'h1234, 8'hC3});
    exp_q.push_back('{1'b1, 25'h8000, 8'h5A});
    ack_q.push_back('{1'b1, 25'h8000, 8'h5A});
    a0 = cpu_acks;
    tick();
    bus.dl_wr = 0;
    wait_cpu_ack(20);
    tick(6);
    check("cpu_ack_once", cpu_acks - a0, 1);
    check("same_cycle_drained", exp_q.size(), 0);

    // CPU drops its request mid-access: access runs, ack suppressed
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 25'h0100;
    exp_q.push_back('{1'b0, 25'h0100, 8'h00});
    a0 = cpu_acks;
    tick(2);
    bus.cpu_req = 0;
    tick(8);
    check("abandon_no_ack", cpu_acks - a0, 0);
    check("abandon_access", exp_q.size(), 0);

`ifdef ARB_VIDEO_PORT_EN
    // Three-way contention: video, download, CPU
    bus.vid_req = 1; bus.vid_addr = 25'h0100;
    bus.dl_wr = 1; bus.dl_addr = 25'h3000; bus.dl_data = 8'h11;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 25'h8001; bus.cpu_wdata = 8'h22;
    exp_q.push_back('{1'b0, 25'h0100, 8'h00});
    exp_q.push_back('{1'b1, 25'h3000, 8'h11});
    exp_q.push_back('{1'b1, 25'h8001, 8'h22});
    ack_q.push_back('{1'b1, 25'h8001, 8'h22});
    a0 = cpu_acks;
    tick();
    bus.dl_wr = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.vid_ack) bus.vid_req = 0;
      if (bus.cpu_ack) bus.cpu_req = 0;
      tick();
    end
    check("vid_ack_once", vid_acks, 1);
    check("three_cpu_ack_once", cpu_acks - a0, 1);
`endif

    tick(4);
    check("sb_mem_empty", exp_q.size(), 0);
    check("sb_ack_empty", ack_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
